// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Mode encodings and pointer sizing live here.
package fifo_pkg;

  localparam int ERR_STICKY_0 = 0;
  localparam int ERR_STICKY_1 = 1;
  localparam int ERR_PREV     = 2;

  localparam int RST_CLR_0  = 0;
  localparam int RST_KEEP_1 = 1;
  localparam int RST_CLR_2  = 2;
  localparam int RST_KEEP_3 = 3;

  function automatic int ptr_w(input int d);
    int w;
    w = 1;
    while ((1 << w) < d) w++;
    return w;
  endfunction

  function automatic bit mem_cleared(input int m);
    return (m == RST_CLR_0) || (m == RST_CLR_2);
  endfunction

endpackage

// File: rtl/dw_fifo_s1_sf.sv
// Single-clock FIFO with registered count, decoded flags and error.
// Head word is a combinational read of storage at the read pointer.
module dw_fifo_s1_sf
  import fifo_pkg::*;
#(
  parameter int width    = 32,
  parameter int depth    = 4,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = 2,
  parameter int rst_mode = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_req_n,
  input  logic             pop_req_n,
  input  logic             diag_n,
  input  logic [width-1:0] data_in,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic             error,
  output logic [width-1:0] data_out
);

  localparam int PW = ptr_w(depth);
  localparam int CW = ptr_w(depth + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(depth);
  localparam logic [CW-1:0] CNT_AE   = CW'(ae_level);
  localparam logic [CW-1:0] CNT_HF   = CW'((depth + 1) / 2);
  localparam logic [CW-1:0] CNT_AF   = CW'(depth - af_level);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;
  logic             ovf;
  logic             unf;
  logic             unused_diag;

  assign unused_diag = diag_n;

  assign empty        = (count == '0);
  assign almost_empty = (count <= CNT_AE);
  assign half_full    = (count >= CNT_HF);
  assign almost_full  = (count >= CNT_AF);
  assign full         = (count == CNT_FULL);

  // A full FIFO still takes a push when a pop frees a slot this cycle.
  assign pop_ok  = !pop_req_n && !empty;
  assign push_ok = !push_req_n && (!full || pop_ok);
  assign ovf     = !push_req_n && full && pop_req_n;
  assign unf     = !pop_req_n && empty;

  assign data_out = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok)
        wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (pop_ok)
        rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      if (push_ok && !pop_ok)
        count <= count + 1'b1;
      else if (pop_ok && !push_ok)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      error <= 1'b0;
    else if (err_mode == ERR_PREV)
      error <= ovf || unf;
    else
      error <= error || ovf || unf;
  end

  generate
    if (mem_cleared(rst_mode)) begin : g_mem_clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          mem <= '{default: '0};
        else if (push_ok)
          mem[wptr] <= data_in;
      end
    end else begin : g_mem_keep
      always_ff @(posedge clk) begin
        if (push_ok)
          mem[wptr] <= data_in;
      end
    end
  endgenerate

endmodule

// File: tb/tb_dw_fifo_s1_sf.sv
// Directed bench: stimulus queues expected head words, a negedge
// monitor checks data_out on every accepted pop.
module tb_dw_fifo_s1_sf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_req_n = 1'b1;
  logic        pop_req_n = 1'b1;
  logic        diag_n = 1'b1;
  logic [31:0] data_in = '0;

  logic        empty, almost_empty, half_full, almost_full, full, error;
  logic [31:0] data_out;
  logic        e0_empty, e0_ae, e0_hf, e0_af, e0_full, e0_error;
  logic [31:0] e0_data;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  dw_fifo_s1_sf #(
    .width(32), .depth(4), .ae_level(1), .af_level(1),
    .err_mode(2), .rst_mode(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n),
    .pop_req_n(pop_req_n), .diag_n(diag_n), .data_in(data_in),
    .empty(empty), .almost_empty(almost_empty), .half_full(half_full),
    .almost_full(almost_full), .full(full), .error(error),
    .data_out(data_out)
  );

  dw_fifo_s1_sf #(
    .width(32), .depth(4), .ae_level(1), .af_level(1),
    .err_mode(0), .rst_mode(0)
  ) dut_e0 (
    .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n),
    .pop_req_n(pop_req_n), .diag_n(diag_n), .data_in(data_in),
    .empty(e0_empty), .almost_empty(e0_ae), .half_full(e0_hf),
    .almost_full(e0_af), .full(e0_full), .error(e0_error),
    .data_out(e0_data)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: an accepted pop must show the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && !pop_req_n && !empty) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_data: got %h want <none queued>", data_out);
      end else begin
        logic [31:0] w;
        w = exp_q.pop_front();
        if (data_out !== w) begin
          bad++;
          $display("FAIL pop_data: got %h want %h", data_out, w);
        end
      end
    end
  end

  task automatic cyc(input logic push, input logic pop,
                     input logic [31:0] d);
    push_req_n = !push;
    pop_req_n  = !pop;
    data_in    = d;
    @(posedge clk);
    #1;
    push_req_n = 1'b1;
    pop_req_n  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fill4();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 32'(i));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, '0);
  endtask

  initial begin
    #2;
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_e0_data", e0_data, 32'h0);

    cyc(1'b1, 1'b0, 32'hA5A5_0001);
    chk("first_empty", 32'(empty), 32'd0);
    chk("first_ae", 32'(almost_empty), 32'd1);
    chk("first_data", data_out, 32'hA5A5_0001);
    exp_q.push_back(32'hA5A5_0001);
    drain(1);
    chk("first_drained", 32'(empty), 32'd1);

    cyc(1'b1, 1'b0, 32'h1);
    cyc(1'b1, 1'b0, 32'h2);
    chk("p2_hf", 32'(half_full), 32'd1);
    chk("p2_ae", 32'(almost_empty), 32'd0);
    chk("p2_af", 32'(almost_full), 32'd0);
    cyc(1'b1, 1'b0, 32'h3);
    chk("p3_af", 32'(almost_full), 32'd1);
    chk("p3_full", 32'(full), 32'd0);
    cyc(1'b1, 1'b0, 32'h4);
    chk("p4_full", 32'(full), 32'd1);
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
    drain(4);
    chk("drain_empty", 32'(empty), 32'd1);

    fill4();
    cyc(1'b1, 1'b0, 32'h0000_DEAD);
    chk("ovf_err", 32'(error), 32'd1);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_e0_err", 32'(e0_error), 32'd1);
    cyc(1'b0, 1'b0, '0);
    chk("ovf_err_clr", 32'(error), 32'd0);
    chk("ovf_e0_sticky", 32'(e0_error), 32'd1);
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
    drain(4);
    chk("ovf_drained", 32'(empty), 32'd1);

    do_reset();
    chk("rst2_e0_err", 32'(e0_error), 32'd0);
    fill4();
    exp_q.push_back(32'h1);
    cyc(1'b1, 1'b1, 32'h5);
    chk("both_full", 32'(full), 32'd1);
    chk("both_err", 32'(error), 32'd0);
    for (int i = 2; i <= 5; i++) exp_q.push_back(32'(i));
    drain(4);
    chk("wrap_empty", 32'(empty), 32'd1);

    cyc(1'b1, 1'b1, 32'h7);
    chk("unf_err", 32'(error), 32'd1);
    chk("unf_empty", 32'(empty), 32'd0);
    chk("unf_ae", 32'(almost_empty), 32'd1);
    chk("unf_hf", 32'(half_full), 32'd0);
    chk("unf_data", data_out, 32'h7);
    chk("unf_e0_err", 32'(e0_error), 32'd1);
    cyc(1'b0, 1'b0, '0);
    chk("unf_err_clr", 32'(error), 32'd0);
    exp_q.push_back(32'h7);
    drain(1);
    cyc(1'b1, 1'b0, 32'h8);
    exp_q.push_back(32'h8);
    drain(1);
    chk("e0_sticky", 32'(e0_error), 32'd1);
    chk("e2_quiet", 32'(error), 32'd0);

    cyc(1'b1, 1'b0, 32'h9);
    cyc(1'b1, 1'b0, 32'hA);
    cyc(1'b1, 1'b0, 32'hB);
    rst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_ae", 32'(almost_empty), 32'd1);
    chk("arst_hf", 32'(half_full), 32'd0);
    chk("arst_af", 32'(almost_full), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_err", 32'(error), 32'd0);
    chk("arst_e0_err", 32'(e0_error), 32'd0);
    chk("arst_e0_data", e0_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 32'h11);
    chk("post_rst_data", data_out, 32'h11);
    chk("post_rst_empty", 32'(empty), 32'd0);
    exp_q.push_back(32'h11);
    drain(1);

    chk("queue_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/dw_fifo_s1_sf.md
Name: dw_fifo_s1_sf

Overview:
- Single-clock synchronous FIFO with registered status flags and an error output.
- Used as the read-data return queue behind the VRF read pipe: each read-result lane has one instance, and the lane's round-robin request arbiter (read_stage_rr_arbiter) is a separate block.
- Push and pop requests are active-low; the oldest word is presented continuously on data_out.

Parameters:
- width, 32: data bits per word; legal 1..256.
- depth, 4: number of words; legal 2..256.
- ae_level, 1: almost_empty threshold; legal 1..depth-1.
- af_level, 1: almost_full margin below full; legal 1..depth-1.
- err_mode, 2: 0 = error sticky, 1 = error sticky, 2 = error non-sticky (shows the previous cycle only).
- rst_mode, 3: 0 and 2 = reset also clears storage; 1 and 3 = storage not reset. Reset is always asynchronous, whatever rst_mode is.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- push_req_n  in  1  active-low write request.
- pop_req_n  in  1  active-low read request.
- diag_n  in  1  reserved diagnostic input; functionally ignored; tie high.
- data_in  in  width  write data.
- empty  out  1  occupancy count == 0.
- almost_empty  out  1  count <= ae_level.
- half_full  out  1  count >= (depth+1)/2.
- almost_full  out  1  count >= depth-af_level.
- full  out  1  count == depth.
- error  out  1  overflow/underflow indication.
- data_out  out  width  word at the head of the FIFO.

Behaviour:
- State:
  - write pointer, read pointer, occupancy count (0..depth), error register.
  - Storage: depth x width register array.
- Reset (rst_n low, asynchronous):
  - Pointers and count go to 0; error goes to 0.
  - Storage is cleared only when rst_mode is 0 or 2.
  - Output values during reset: empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0.
  - data_out = storage[0]: zero when rst_mode is 0 or 2, otherwise undefined.
- Flags: combinational decodes of the registered count only; no combinational path from the request inputs.
- Push accepted when push_req_n=0 and (full=0, or pop_req_n=0 with empty=0):
  - storage[wptr] <= data_in;
  - wptr advances modulo depth.
- Pop accepted when pop_req_n=0 and empty=0: rptr advances modulo depth.
- Count update: +1 on push only, -1 on pop only, unchanged when both are accepted.
- data_out = storage[rptr], a combinational read with zero pop latency.
  - A word pushed into an empty FIFO at edge N appears on data_out after edge N, with empty=0 in the same cycle.
- Full with both push and pop requested: both are accepted, count stays at depth, no error.
- Overflow: push_req_n=0, full=1, pop_req_n=1.
  - Data is dropped; pointers and count are unchanged.
- Underflow: pop_req_n=0 and empty=1.
  - The pop is ignored. A simultaneous push is still accepted.
- Error register:
  - err_mode 0/1: set by overflow or underflow; cleared only by reset.
  - err_mode 2: error <= (overflow | underflow) each cycle.
- Pointers wrap at depth; depth need not be a power of two.
- diag_n has no effect for any err_mode.
- Reset asserted mid-operation discards all contents immediately. Pushes in the first cycle after release proceed normally.

Decomposition:
- Shared package fifo_pkg holds:
  - err_mode and rst_mode encodings as named constants;
  - a pointer-width helper (ceil log2 of depth, minimum 1).
- Single module; storage is an internal register array. No sub-module.
- The round-robin arbiter is a separate block and is not instantiated here.

Test Plan (depth=4, ae_level=1, af_level=1, err_mode=2, width=32):
- Reset then idle -> empty=1, almost_empty=1, full=0, error=0. Push 0xA5A5_0001 -> next cycle empty=0, almost_empty=1, data_out=0xA5A5_0001.
- Push 0x1, 0x2, 0x3, 0x4 -> flags:
  - after 2 pushes: half_full=1, almost_empty=0;
  - after 3: almost_full=1;
  - after 4: full=1.
  - Then pop four times -> data_out sequence 0x1, 0x2, 0x3, 0x4; empty=1 at the end.
- Full, then push 0xDEAD alone -> error=1 for exactly one cycle; contents unchanged; pops return 0x1..0x4.
- Full, then simultaneous push 0x5 and pop -> full stays 1, error=0; subsequent pops return 0x2, 0x3, 0x4, 0x5 (pointers wrap).
- Empty, then pop with push 0x7 -> error=1 next cycle; count=1; data_out=0x7.
- err_mode=0 variant: one underflow -> error stays 1 across later legal traffic. Assert rst_n low mid-stream -> all flags return to reset values asynchronously, before the next clock edge.
